// File: rtl/step_pulse_timer.sv
// step_pulse_timer: per-axis STEP/DIR output stage for one stepper driver.
// Shapes single-cycle step requests into driver-legal waveforms: DIR setup
// before the STEP rising edge, minimum STEP high time and minimum low gap.
// One request can wait in a pending slot; further requests are dropped and
// flagged on the sticky overrun output.
// Optional feature macro: STEP_POSITION_EN adds a signed 32-bit count of the
// steps actually emitted (the `position` port).
module step_pulse_timer #(
    parameter int DIR_SETUP   = 50,
    parameter int PULSE_WIDTH = 100,
    parameter int PULSE_GAP   = 100,
    parameter int CNT_W       = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        step_in,
    input  logic        dir_in,
    input  logic        enable,
    input  logic        clr_overrun,
    output logic        out_step,
    output logic        out_dir,
    output logic        busy,
    output logic        overrun
`ifdef STEP_POSITION_EN
    ,
    output logic signed [31:0] position
`endif
);

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, GAP} state_t;

    // The counter counts down to zero and the phase ends on the edge that
    // sees zero, so each phase lasts exactly its parameter in cycles.
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(DIR_SETUP - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_WIDTH - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(PULSE_GAP - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             slot_v_q, slot_v_d;
    logic             slot_dir_q, slot_dir_d;
    logic             out_step_q, out_step_d;
    logic             out_dir_q, out_dir_d;
    logic             busy_q, busy_d;
    logic             overrun_q, overrun_d;

    logic             req;
    logic             expire;
    logic             start;
    logic             start_dir;
    logic             drop;

    // Next-state logic: phase sequencing, pending slot and overrun tracking.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        slot_v_d   = slot_v_q;
        slot_dir_d = slot_dir_q;
        out_step_d = out_step_q;
        out_dir_d  = out_dir_q;
        overrun_d  = overrun_q;
        req        = step_in & enable;
        expire     = (cnt_q == '0);
        start      = 1'b0;
        start_dir  = dir_in;
        drop       = 1'b0;

        if (!enable) begin
            // Abort: pulse may be truncated, DIR pin keeps its level.
            state_d    = IDLE;
            out_step_d = 1'b0;
            slot_v_d   = 1'b0;
            cnt_d      = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req) begin
                        start     = 1'b1;
                        start_dir = dir_in;
                    end
                end
                SETUP: begin
                    if (expire) begin
                        out_step_d = 1'b1;
                        cnt_d      = PULSE_LD;
                        state_d    = PULSE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                PULSE: begin
                    if (expire) begin
                        out_step_d = 1'b0;
                        cnt_d      = GAP_LD;
                        state_d    = GAP;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                GAP: begin
                    if (expire) begin
                        if (slot_v_q) begin
                            // Older pending request goes first; a new one
                            // arriving now takes its place in the slot.
                            start      = 1'b1;
                            start_dir  = slot_dir_q;
                            slot_v_d   = req;
                            slot_dir_d = dir_in;
                        end else if (req) begin
                            start     = 1'b1;
                            start_dir = dir_in;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase

            // Requests arriving while a step is in flight queue or drop.
            if (req && state_q != IDLE && !(state_q == GAP && expire)) begin
                if (!slot_v_q) begin
                    slot_v_d   = 1'b1;
                    slot_dir_d = dir_in;
                end else begin
                    drop = 1'b1;
                end
            end

            // A direction change must settle on the DIR pin before STEP rises.
            if (start) begin
                if (start_dir != out_dir_q) begin
                    out_dir_d = start_dir;
                    cnt_d     = SETUP_LD;
                    state_d   = SETUP;
                end else begin
                    out_step_d = 1'b1;
                    cnt_d      = PULSE_LD;
                    state_d    = PULSE;
                end
            end
        end

        if (drop) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end

        busy_d = (state_d != IDLE) | slot_v_d;
    end

    // State and registered output flops.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            slot_v_q   <= 1'b0;
            slot_dir_q <= 1'b0;
            out_step_q <= 1'b0;
            out_dir_q  <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            slot_v_q   <= slot_v_d;
            slot_dir_q <= slot_dir_d;
            out_step_q <= out_step_d;
            out_dir_q  <= out_dir_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
        end
    end

    assign out_step = out_step_q;
    assign out_dir  = out_dir_q;
    assign busy     = busy_q;
    assign overrun  = overrun_q;

`ifdef STEP_POSITION_EN
    logic [31:0] position_q, position_d;

    // Count each STEP rising edge in the direction presented on the DIR pin.
    always_comb begin
        position_d = position_q;
        if (out_step_d && !out_step_q) begin
            position_d = position_q + (out_dir_d ? 32'd1 : 32'hFFFF_FFFF);
        end
    end

    // Position register; wraps naturally at 32 bits.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            position_q <= '0;
        end else begin
            position_q <= position_d;
        end
    end

    assign position = position_q;
`endif

endmodule

// File: doc/step_pulse_timer.md
# step_pulse_timer

Per-axis output stage placed directly downstream of the step/dir motor multiplexer; drives the physical STEP/DIR pins of one stepper driver. Turns single-cycle step requests into driver-legal waveforms: direction setup time before the step edge, minimum high time, minimum low gap. Buffers one pending step and flags overrun when requests come faster than the driver timing allows. Optionally keeps a signed position count of the steps actually emitted.

## Interface
- DIR_SETUP, 50: cycles from an `out_dir` change to the `out_step` rising edge; ≥1.
- PULSE_WIDTH, 100: `out_step` high time in cycles; ≥1.
- PULSE_GAP, 100: minimum `out_step` low time after each pulse, in cycles; ≥1.
- CNT_W, 16: timer width; every timing parameter must be < 2^CNT_W.
- clk  in  1  system clock.
- resetn  in  1  reset, asynchronous, active-low.
- step_in  in  1  step request, one-cycle pulse (muxed step from the motor mux).
- dir_in  in  1  requested direction, sampled together with `step_in`.
- enable  in  1  channel enable; low aborts and ignores requests.
- clr_overrun  in  1  clears the sticky `overrun` flag.
- out_step  out  1  driver STEP pin.
- out_dir  out  1  driver DIR pin.
- busy  out  1  high when state≠IDLE or a step is pending.
- overrun  out  1  sticky; a request was dropped.
- position  out  32  signed emitted-step count (only with STEP_POSITION_EN).

## Operation
- States: IDLE, SETUP, PULSE, GAP. One down-counter (CNT_W bits) and one pending slot (valid bit + dir bit).
- Start of a step with direction d (from `step_in`/`dir_in`, or from the pending slot):
  - d≠`out_dir`: set `out_dir`←d, load DIR_SETUP, go to SETUP.
  - Otherwise: set `out_step`←1, load PULSE_WIDTH, go to PULSE.
- SETUP: counter expiry sets `out_step`←1, loads PULSE_WIDTH, goes to PULSE.
- PULSE: counter expiry sets `out_step`←0, loads PULSE_GAP, goes to GAP.
- GAP: counter expiry either starts the pending step (clears the slot) or goes to IDLE.
- IDLE: `step_in`&`enable` starts a step.
- `step_in`&`enable` outside IDLE:
  - slot empty: store the request in the slot.
  - slot full: drop the request and set `overrun`.
- Same cycle as GAP expiry:
  - slot empty: the new request starts directly.
  - slot full: the slot's request starts and the new request fills the slot; no overrun.
- `enable` low: next cycle state=IDLE, `out_step`=0, slot cleared, counter cleared. `out_dir` is held. `step_in` is ignored. Truncating a pulse mid-way is intended behaviour.
- `overrun` is set by a drop and cleared by `clr_overrun`. If both happen in the same cycle, set wins.
- Reset values: `out_step`=0, `out_dir`=0, `busy`=0, `overrun`=0, `position`=0, state IDLE, slot empty. Reset mid-pulse drops `out_step` asynchronously.

## Timing
- Request sampled at edge k, same direction: `out_step` is high for cycles k+1 … k+PULSE_WIDTH; low for at least PULSE_GAP cycles after that.
- Direction change: `out_dir` toggles at k+1; `out_step` rises at k+1+DIR_SETUP.
- Back-to-back same-direction steps via the slot: rising-edge period is exactly PULSE_WIDTH+PULSE_GAP.
- `out_dir` never changes while `out_step`=1 or during GAP.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- STEP_POSITION_EN defined:
  - `position` adds +1 (`out_dir`=1) or −1 (`out_dir`=0) in the cycle `out_step` rises.
  - Wraps two's-complement at 32 bits.
  - Aborted pulses still count if they rose.
- STEP_POSITION_EN undefined: `position` port and counter are absent; all other behaviour is identical.

## Test plan
All scenarios use DIR_SETUP=3, PULSE_WIDTH=4, PULSE_GAP=2.
- Reset, then a single `step_in` with `dir_in`=0 at cycle 10 → `out_step` high cycles 11–14; `busy` falls at cycle 17; `position`=−1.
- `step_in` with `dir_in`=1 at cycle 10 → `out_dir`=1 at cycle 11; `out_step` high cycles 14–17; `position`=+1.
- Three same-direction requests on cycles 10, 11, 12 → `out_step` rises at 11 and 17; third request dropped; `overrun`=1 until `clr_overrun` is pulsed.
- Request at cycle 10, second request at cycle 16 (GAP expiry, slot empty) → second pulse rises at cycle 17; `overrun` stays 0.
- Request at cycle 10, `enable` low at cycle 12 → `out_step`=0 at cycle 13; `busy`=0; `step_in` with `enable`=0 gives no pulse.
- Without STEP_POSITION_EN → design elaborates with no `position` port; waveforms match the first scenario.
